instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Upstream stage of the control matrix: owns the 2-bit micro-step counter `state`, the instruction register and opcode decode.
//  Fetches one 16-bit instruction word per instruction and steps state 0->1->..->last, with the last step chosen per opcode.
//  Then returns to 0 for the next fetch. Also handles start/halt, illegal-opcode trapping and run statistics.
// PARAMETERS
//  INSTR_WIDTH  16  instruction word width; [15:12] opcode, [11:8] field_a, [7:4] field_b, [3:0] imm
//  CNT_WIDTH    16  width of cycle_count and retired_count
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   begin execution; sampled only when not running
//  halt_req       in   1   stop after the current instruction retires
//  sm_reset       in   1   synchronous abort of the current instruction, back to state 0 (state_machine_reset)
//  instr_word     in   16  instruction word from program memory
//  instr_valid    in   1   instr_word is valid this cycle
//  fetch_req      out  1   requesting an instruction; high in state 0 while running
//  state          out  2   micro-step to the control matrix
//  opcode         out  4   IR[15:12]
//  field_a        out  4   IR[11:8]
//  field_b        out  4   IR[7:4]
//  imm            out  4   IR[3:0]
//  running        out  1   sequencer active
//  instr_done     out  1   high during the final micro-step of a legal instruction
//  illegal_op     out  1   sticky: an opcode of 4'b1000..4'b1111 was decoded
//  cycle_count    out  CNT_WIDTH  clocks spent running; saturates at all-ones
//  retired_count  out  CNT_WIDTH  legal instructions completed; wraps
// BEHAVIOUR
//  Reset values: every output is 0 (running=0, state=0, IR=0, fetch_req=0, illegal_op=0, both counters 0). Reset takes effect immediately, including mid-instruction.
//  IDLE (running=0):
//   - state is held at 0.
//   - start=1 sets running=1 on the next edge and clears illegal_op.
//   - start is ignored while running.
//  state 0 (fetch):
//   - fetch_req = running.
//   - On an edge with instr_valid=1: IR <= instr_word and state <= 1.
//   - Otherwise state stays 0 (stall) and IR is held.
//  Last step per opcode:
//   - 0000 OUT = 1; 0001 JMP = 1; 0100 RTR = 2; 0101 BLT = 2.
//   - 0010 LDW = 3; 0011 STW = 3; 0110 ADD = 3; 0111 SUB = 3.
//  Steps 1..last:
//   - state increments each clock.
//   - When state == last: instr_done = 1 (combinational from registered state and IR); next state is 0 and retired_count increments.
//  Illegal opcode (IR[15] = 1):
//   - In state 1: instr_done = 0, no retire.
//   - Next edge: state <= 0, running <= 0, illegal_op <= 1.
//  halt_req:
//   - Sampled at any edge where instr_done = 1, or in state 0 with no fetch accepted.
//   - The effect is running <= 0 and state <= 0.
//   - A halt_req arriving mid-instruction is remembered (pending flag) until that boundary.
//  sm_reset (synchronous):
//   - Priority above everything except reset.
//   - Next state = 0; IR, running and the counters are held.
//   - If it coincides with the last step, instr_done is still high that cycle but the retire is suppressed.
//  Simultaneous events: in state 0, instr_valid together with halt_req -> halt wins and the word is not latched.
//  cycle_count: +1 on every edge with running = 1; holds at 2^CNT_WIDTH-1.
//  Latency: instruction latency is (last + 1) clocks from fetch acceptance; no extra bubble between back-to-back instructions.
// TESTING
//  1. Reset; start; instr_valid=1 with word 16'h2123 (LDW) -> state 0,1,2,3,0; instr_done in state 3; retired_count=1; opcode=2.
//  2. In state 0 hold instr_valid=0 for 5 clocks -> state stays 0, fetch_req=1, cycle_count advances by 5; then ADD 16'h6000 runs 0..3.
//  3. Word 16'h9000 -> state 1 then 0; running=0; illegal_op=1; retired_count unchanged; a later start clears illegal_op.
//  4. sm_reset asserted in state 2 of STW (16'h3000) -> state 0 next clock; retired_count unchanged; next fetch proceeds normally.
//  5. reset asserted mid-edge during state 2 -> all outputs 0 immediately; start and RTR 16'h4000 -> states 0,1,2.
//  6. halt_req pulsed in state 1 of SUB -> SUB completes, retires, then running=0; with CNT_WIDTH=4, cycle_count saturates at 15.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches one instruction word, steps the micro-step counter
// through each opcode's steps, and tracks start/halt, illegal-opcode traps and run statistics.
module instruction_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_halt_req,
    input  logic                   i_sm_reset,
    input  logic [INSTR_WIDTH-1:0] i_instr_word,
    input  logic                   i_instr_valid,
    output logic                   o_fetch_req,
    output logic [1:0]             o_state,
    output logic [3:0]             o_opcode,
    output logic [3:0]             o_field_a,
    output logic [3:0]             o_field_b,
    output logic [3:0]             o_imm,
    output logic                   o_running,
    output logic                   o_instr_done,
    output logic                   o_illegal_op,
    output logic [CNT_WIDTH-1:0]   o_cycle_count,
    output logic [CNT_WIDTH-1:0]   o_retired_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STEP1 = 2'd1,
        S_STEP2 = 2'd2,
        S_STEP3 = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [INSTR_WIDTH-1:0] w_irNext;
    logic                   r_running;
    logic                   w_runningNext;
    logic                   r_illegal;
    logic                   w_illegalNext;
    logic                   r_haltPending;
    logic                   w_haltPendingNext;
    logic                   w_retire;
    logic [CNT_WIDTH-1:0]   r_cycleCount;
    logic [CNT_WIDTH-1:0]   r_retiredCount;
    logic [3:0]             w_opcode;
    logic                   w_isIllegal;
    logic                   w_haltNow;
    state_t                 w_lastStep;

    assign w_opcode    = r_ir[INSTR_WIDTH-1 -: 4];
    assign w_isIllegal = w_opcode[3];
    assign w_haltNow   = i_halt_req | r_haltPending;

    always_comb begin
        w_lastStep = S_STEP1;
        case (w_opcode)
            4'h0, 4'h1:             w_lastStep = S_STEP1;
            4'h4, 4'h5:             w_lastStep = S_STEP2;
            4'h2, 4'h3, 4'h6, 4'h7: w_lastStep = S_STEP3;
            default:                w_lastStep = S_STEP1;
        endcase
    end

    assign o_instr_done = r_running && (r_state != S_FETCH) && !w_isIllegal
                          && (r_state == w_lastStep);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_FETCH;
            r_ir          <= '0;
            r_running     <= 1'b0;
            r_illegal     <= 1'b0;
            r_haltPending <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_ir          <= w_irNext;
            r_running     <= w_runningNext;
            r_illegal     <= w_illegalNext;
            r_haltPending <= w_haltPendingNext;
        end
    end

    // sm_reset only rewinds the micro-step; everything else keeps its value.
    always_comb begin
        w_stateNext       = r_state;
        w_irNext          = r_ir;
        w_runningNext     = r_running;
        w_illegalNext     = r_illegal;
        w_haltPendingNext = r_haltPending;
        w_retire          = 1'b0;
        if (i_sm_reset) begin
            w_stateNext = S_FETCH;
        end else if (!r_running) begin
            w_stateNext = S_FETCH;
            if (i_start) begin
                w_runningNext = 1'b1;
                w_illegalNext = 1'b0;
            end
        end else if (r_state == S_FETCH) begin
            if (w_haltNow) begin
                w_runningNext     = 1'b0;
                w_haltPendingNext = 1'b0;
            end else if (i_instr_valid) begin
                w_irNext    = i_instr_word;
                w_stateNext = S_STEP1;
            end
        end else if (w_isIllegal) begin
            w_stateNext       = S_FETCH;
            w_runningNext     = 1'b0;
            w_illegalNext     = 1'b1;
            w_haltPendingNext = 1'b0;
        end else if (r_state == w_lastStep) begin
            w_stateNext = S_FETCH;
            w_retire    = 1'b1;
            if (w_haltNow) begin
                w_runningNext     = 1'b0;
                w_haltPendingNext = 1'b0;
            end
        end else begin
            w_stateNext = state_t'(r_state + 2'd1);
            if (i_halt_req) begin
                w_haltPendingNext = 1'b1;
            end
        end
    end

    // Cycle counter saturates, retire counter wraps; both freeze during sm_reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cycleCount   <= '0;
            r_retiredCount <= '0;
        end else if (!i_sm_reset) begin
            if (r_running && (r_cycleCount != '1)) begin
                r_cycleCount <= r_cycleCount + 1'b1;
            end
            if (w_retire) begin
                r_retiredCount <= r_retiredCount + 1'b1;
            end
        end
    end

    assign o_fetch_req     = r_running && (r_state == S_FETCH);
    assign o_state         = r_state;
    assign o_opcode        = w_opcode;
    assign o_field_a       = r_ir[11:8];
    assign o_field_b       = r_ir[7:4];
    assign o_imm           = r_ir[3:0];
    assign o_running       = r_running;
    assign o_illegal_op    = r_illegal;
    assign o_cycle_count   = r_cycleCount;
    assign o_retired_count = r_retiredCount;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer; a second 4-bit-counter instance
// shares the stimulus to exercise cycle_count saturation.
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        haltReq = 1'b0;
    logic        smReset = 1'b0;
    logic [15:0] instrWord = 16'h0;
    logic        instrValid = 1'b0;

    logic        fetchReq, running, instrDone, illegalOp;
    logic [1:0]  state;
    logic [3:0]  opcode, fieldA, fieldB, imm;
    logic [15:0] cycleCount, retiredCount;

    logic        sFetchReq, sRunning, sInstrDone, sIllegalOp;
    logic [1:0]  sState;
    logic [3:0]  sOpcode, sFieldA, sFieldB, sImm;
    logic [3:0]  sCycleCount, sRetiredCount;

    int nChecks = 0;
    int nFails  = 0;

    instruction_sequencer #(.INSTR_WIDTH(16), .CNT_WIDTH(16)) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_halt_req(haltReq),
        .i_sm_reset(smReset), .i_instr_word(instrWord), .i_instr_valid(instrValid),
        .o_fetch_req(fetchReq), .o_state(state), .o_opcode(opcode), .o_field_a(fieldA),
        .o_field_b(fieldB), .o_imm(imm), .o_running(running), .o_instr_done(instrDone),
        .o_illegal_op(illegalOp), .o_cycle_count(cycleCount), .o_retired_count(retiredCount)
    );

    instruction_sequencer #(.INSTR_WIDTH(16), .CNT_WIDTH(4)) dutSmall (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_halt_req(haltReq),
        .i_sm_reset(smReset), .i_instr_word(instrWord), .i_instr_valid(instrValid),
        .o_fetch_req(sFetchReq), .o_state(sState), .o_opcode(sOpcode), .o_field_a(sFieldA),
        .o_field_b(sFieldB), .o_imm(sImm), .o_running(sRunning), .o_instr_done(sInstrDone),
        .o_illegal_op(sIllegalOp), .o_cycle_count(sCycleCount), .o_retired_count(sRetiredCount)
    );

    always #5 clock = ~clock;

    // Outputs are observed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL reset_state got %0d exp 0", state); end
        nChecks++; if (running !== 1'b0) begin nFails++; $display("[TB] FAIL reset_running got %0d exp 0", running); end
        nChecks++; if (fetchReq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_fetch_req got %0d exp 0", fetchReq); end
        nChecks++; if ({opcode, fieldA, fieldB, imm} !== 16'h0) begin nFails++; $display("[TB] FAIL reset_ir got %h exp 0000", {opcode, fieldA, fieldB, imm}); end
        nChecks++; if (cycleCount !== 16'd0 || retiredCount !== 16'd0) begin nFails++; $display("[TB] FAIL reset_counts got %0d/%0d exp 0/0", cycleCount, retiredCount); end
        reset = 1'b0;
    endtask

    task automatic test_ldw();
        start = 1'b1;
        tick();
        start = 1'b0;
        nChecks++; if (running !== 1'b1 || fetchReq !== 1'b1) begin nFails++; $display("[TB] FAIL start_running got %0d/%0d exp 1/1", running, fetchReq); end
        instrValid = 1'b1; instrWord = 16'h2123;
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL ldw_state1 got %0d exp 1", state); end
        nChecks++; if ({opcode, fieldA, fieldB, imm} !== 16'h2123) begin nFails++; $display("[TB] FAIL ldw_fields got %h exp 2123", {opcode, fieldA, fieldB, imm}); end
        nChecks++; if (fetchReq !== 1'b0 || instrDone !== 1'b0) begin nFails++; $display("[TB] FAIL ldw_s1_flags got %0d/%0d exp 0/0", fetchReq, instrDone); end
        tick();
        nChecks++; if (state !== 2'd2 || instrDone !== 1'b0) begin nFails++; $display("[TB] FAIL ldw_state2 got %0d/%0d exp 2/0", state, instrDone); end
        tick();
        nChecks++; if (state !== 2'd3 || instrDone !== 1'b1) begin nFails++; $display("[TB] FAIL ldw_state3_done got %0d/%0d exp 3/1", state, instrDone); end
        tick();
        nChecks++; if (state !== 2'd0 || retiredCount !== 16'd1) begin nFails++; $display("[TB] FAIL ldw_retire got %0d/%0d exp 0/1", state, retiredCount); end
        nChecks++; if (cycleCount !== 16'd4) begin nFails++; $display("[TB] FAIL ldw_cycles got %0d exp 4", cycleCount); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) tick();
        nChecks++; if (state !== 2'd0 || fetchReq !== 1'b1) begin nFails++; $display("[TB] FAIL stall_state got %0d/%0d exp 0/1", state, fetchReq); end
        nChecks++; if (cycleCount !== 16'd9) begin nFails++; $display("[TB] FAIL stall_cycles got %0d exp 9", cycleCount); end
        nChecks++; if (opcode !== 4'h2) begin nFails++; $display("[TB] FAIL stall_ir_held got %0d exp 2", opcode); end
        instrValid = 1'b1; instrWord = 16'h6000;
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1 || opcode !== 4'h6) begin nFails++; $display("[TB] FAIL add_state1 got %0d/%0d exp 1/6", state, opcode); end
        tick();
        tick();
        nChecks++; if (state !== 2'd3 || instrDone !== 1'b1) begin nFails++; $display("[TB] FAIL add_state3_done got %0d/%0d exp 3/1", state, instrDone); end
        tick();
        nChecks++; if (state !== 2'd0 || retiredCount !== 16'd2 || cycleCount !== 16'd13) begin nFails++; $display("[TB] FAIL add_retire got %0d/%0d/%0d exp 0/2/13", state, retiredCount, cycleCount); end
    endtask

    task automatic test_illegal();
        instrValid = 1'b1; instrWord = 16'h9000;
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1 || instrDone !== 1'b0) begin nFails++; $display("[TB] FAIL ill_state1 got %0d/%0d exp 1/0", state, instrDone); end
        tick();
        nChecks++; if (state !== 2'd0 || running !== 1'b0 || illegalOp !== 1'b1) begin nFails++; $display("[TB] FAIL ill_trap got %0d/%0d/%0d exp 0/0/1", state, running, illegalOp); end
        nChecks++; if (retiredCount !== 16'd2 || fetchReq !== 1'b0) begin nFails++; $display("[TB] FAIL ill_no_retire got %0d/%0d exp 2/0", retiredCount, fetchReq); end
        tick();
        nChecks++; if (illegalOp !== 1'b1 || cycleCount !== 16'd15) begin nFails++; $display("[TB] FAIL ill_sticky got %0d/%0d exp 1/15", illegalOp, cycleCount); end
        start = 1'b1;
        tick();
        start = 1'b0;
        nChecks++; if (running !== 1'b1 || illegalOp !== 1'b0) begin nFails++; $display("[TB] FAIL ill_restart got %0d/%0d exp 1/0", running, illegalOp); end
    endtask

    task automatic test_sm_reset();
        instrValid = 1'b1; instrWord = 16'h3000;
        tick();
        instrValid = 1'b0;
        tick();
        nChecks++; if (state !== 2'd2) begin nFails++; $display("[TB] FAIL smr_pre_state got %0d exp 2", state); end
        smReset = 1'b1;
        tick();
        smReset = 1'b0;
        nChecks++; if (state !== 2'd0 || running !== 1'b1 || opcode !== 4'h3) begin nFails++; $display("[TB] FAIL smr_abort got %0d/%0d/%0d exp 0/1/3", state, running, opcode); end
        nChecks++; if (retiredCount !== 16'd2) begin nFails++; $display("[TB] FAIL smr_no_retire got %0d exp 2", retiredCount); end
        instrValid = 1'b1; instrWord = 16'h0000;
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1 || instrDone !== 1'b1 || opcode !== 4'h0) begin nFails++; $display("[TB] FAIL smr_out_done got %0d/%0d/%0d exp 1/1/0", state, instrDone, opcode); end
        tick();
        nChecks++; if (state !== 2'd0 || retiredCount !== 16'd3) begin nFails++; $display("[TB] FAIL smr_out_retire got %0d/%0d exp 0/3", state, retiredCount); end
    endtask

    task automatic test_back_to_back();
        instrValid = 1'b1; instrWord = 16'h4000;
        tick();
        tick();
        nChecks++; if (state !== 2'd2 || instrDone !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_rtr_done got %0d/%0d exp 2/1", state, instrDone); end
        instrWord = 16'h5123;
        tick();
        nChecks++; if (state !== 2'd0 || fetchReq !== 1'b1 || retiredCount !== 16'd4) begin nFails++; $display("[TB] FAIL b2b_fetch got %0d/%0d/%0d exp 0/1/4", state, fetchReq, retiredCount); end
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1 || {opcode, fieldA, fieldB, imm} !== 16'h5123) begin nFails++; $display("[TB] FAIL b2b_blt_latch got %0d/%h exp 1/5123", state, {opcode, fieldA, fieldB, imm}); end
        tick();
        tick();
        nChecks++; if (state !== 2'd0 || retiredCount !== 16'd5 || cycleCount !== 16'd25) begin nFails++; $display("[TB] FAIL b2b_retire got %0d/%0d/%0d exp 0/5/25", state, retiredCount, cycleCount); end
    endtask

    task automatic test_halt();
        instrValid = 1'b1; instrWord = 16'h7000;
        tick();
        instrValid = 1'b0;
        haltReq = 1'b1;
        tick();
        haltReq = 1'b0;
        nChecks++; if (state !== 2'd2 || running !== 1'b1) begin nFails++; $display("[TB] FAIL halt_continue got %0d/%0d exp 2/1", state, running); end
        tick();
        nChecks++; if (state !== 2'd3 || instrDone !== 1'b1 || running !== 1'b1) begin nFails++; $display("[TB] FAIL halt_sub_done got %0d/%0d/%0d exp 3/1/1", state, instrDone, running); end
        tick();
        nChecks++; if (state !== 2'd0 || running !== 1'b0 || retiredCount !== 16'd6) begin nFails++; $display("[TB] FAIL halt_stop got %0d/%0d/%0d exp 0/0/6", state, running, retiredCount); end
        tick();
        nChecks++; if (running !== 1'b0 || cycleCount !== 16'd29) begin nFails++; $display("[TB] FAIL halt_idle got %0d/%0d exp 0/29", running, cycleCount); end
        nChecks++; if (sCycleCount !== 4'd15) begin nFails++; $display("[TB] FAIL cnt_saturate got %0d exp 15", sCycleCount); end
        start = 1'b1;
        tick();
        start = 1'b0;
        haltReq = 1'b1; instrValid = 1'b1; instrWord = 16'h2000;
        tick();
        haltReq = 1'b0; instrValid = 1'b0;
        nChecks++; if (running !== 1'b0 || state !== 2'd0 || opcode !== 4'h7) begin nFails++; $display("[TB] FAIL halt_beats_fetch got %0d/%0d/%0d exp 0/0/7", running, state, opcode); end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        instrValid = 1'b1; instrWord = 16'h3000;
        tick();
        instrValid = 1'b0;
        tick();
        nChecks++; if (state !== 2'd2) begin nFails++; $display("[TB] FAIL areset_pre got %0d exp 2", state); end
        #2 reset = 1'b1;
        #1;
        nChecks++; if (state !== 2'd0 || running !== 1'b0 || opcode !== 4'h0) begin nFails++; $display("[TB] FAIL areset_now got %0d/%0d/%0d exp 0/0/0", state, running, opcode); end
        nChecks++; if (cycleCount !== 16'd0 || retiredCount !== 16'd0 || illegalOp !== 1'b0) begin nFails++; $display("[TB] FAIL areset_counts got %0d/%0d/%0d exp 0/0/0", cycleCount, retiredCount, illegalOp); end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        instrValid = 1'b1; instrWord = 16'h4000;
        tick();
        instrValid = 1'b0;
        nChecks++; if (state !== 2'd1 || opcode !== 4'h4) begin nFails++; $display("[TB] FAIL areset_rtr1 got %0d/%0d exp 1/4", state, opcode); end
        tick();
        nChecks++; if (state !== 2'd2 || instrDone !== 1'b1) begin nFails++; $display("[TB] FAIL areset_rtr2 got %0d/%0d exp 2/1", state, instrDone); end
        tick();
        nChecks++; if (state !== 2'd0 || retiredCount !== 16'd1 || cycleCount !== 16'd3) begin nFails++; $display("[TB] FAIL areset_rtr_retire got %0d/%0d/%0d exp 0/1/3", state, retiredCount, cycleCount); end
    endtask

    initial begin
        test_reset();
        test_ldw();
        test_stall();
        test_illegal();
        test_sm_reset();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
